// File: rtl/cam_hex_tx_if.sv
// Request and byte-stream bundle for the CAM console hex response transmitter.
// slave: the transmitter. master: the console FSM feeding requests and the
// usb_uart input pipeline consuming bytes.
interface cam_hex_tx_if #(
    parameter int unsigned DATA_BITS = 100
);
    logic                 req_valid;
    logic                 req_ready;
    logic [DATA_BITS-1:0] req_data;
    logic [7:0]           req_nibbles;
    logic [7:0]           uart_in_data;
    logic                 uart_in_valid;
    logic                 uart_in_ready;
    logic                 busy;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_nibbles,
        input  uart_in_ready,
        output req_ready,
        output uart_in_data,
        output uart_in_valid,
        output busy
    );

    modport master (
        output req_valid,
        output req_data,
        output req_nibbles,
        output uart_in_ready,
        input  req_ready,
        input  uart_in_data,
        input  uart_in_valid,
        input  busy
    );
endinterface

// File: rtl/cam_hex_tx.sv
// Renders one binary word as uppercase ASCII hex (MSB nibble first) followed by
// CR LF, streamed one byte per transfer into the usb_uart input pipeline.
module cam_hex_tx #(
    parameter int unsigned DATA_BITS = 100
) (
    input logic         clk_48mhz,
    input logic         reset,
    cam_hex_tx_if.slave bus
);
    localparam int unsigned MAX_NIBBLES = (DATA_BITS + 3) / 4;
    localparam int unsigned PAD_BITS    = 4 * MAX_NIBBLES;
    localparam int unsigned CNT_W       = $clog2(MAX_NIBBLES + 1);

    typedef enum logic [1:0] {StIdle, StHex, StCr, StLf} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;       // hex digits still to send
    logic [PAD_BITS-1:0] shreg_q, shreg_d;   // word captured at accept
    logic [7:0]          data_q, data_d;
    logic                valid_q, valid_d;

    logic [PAD_BITS-1:0] req_pad;
    logic [CNT_W-1:0]    req_n;
    logic                fire;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    function automatic logic [3:0] nibble_at(input logic [PAD_BITS-1:0] word,
                                             input logic [CNT_W-1:0]    idx);
        logic [PAD_BITS-1:0] sh;
        sh = word >> {idx, 2'b00};
        return sh[3:0];
    endfunction

    // Zero-extend to whole nibbles so every digit index reads defined bits.
    assign req_pad = PAD_BITS'(bus.req_data);
    assign req_n   = (bus.req_nibbles > 8'(MAX_NIBBLES)) ? CNT_W'(MAX_NIBBLES)
                                                         : CNT_W'(bus.req_nibbles);
    assign fire    = valid_q && bus.uart_in_ready;

    assign bus.req_ready     = (state_q == StIdle);
    assign bus.busy          = (state_q != StIdle);
    assign bus.uart_in_data  = data_q;
    assign bus.uart_in_valid = valid_q;

    // State and registered byte outputs; reset abandons any message in flight.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Next state and next byte; a byte only changes on the cycle it transfers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    shreg_d = req_pad;
                    cnt_d   = req_n;
                    valid_d = 1'b1;
                    if (req_n != '0) begin
                        state_d = StHex;
                        data_d  = hex_ascii(nibble_at(req_pad, req_n - CNT_W'(1)));
                    end else begin
                        state_d = StCr;
                        data_d  = 8'h0D;
                    end
                end
            end
            StHex: begin
                if (fire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StCr;
                        data_d  = 8'h0D;
                    end else begin
                        data_d = hex_ascii(nibble_at(shreg_q, cnt_q - CNT_W'(2)));
                    end
                end
            end
            StCr: begin
                if (fire) begin
                    state_d = StLf;
                    data_d  = 8'h0A;
                end
            end
            StLf: begin
                if (fire) begin
                    state_d = StIdle;
                    data_d  = 8'h00;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end
endmodule
